// File: rtl/riscv_br_pkg.sv
// Shared definitions for the branch resolution slice: funct3 codes,
// shared-ALU op encodings and the controller state enum.
package riscv_br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [3:0] ALU_OP_NONE = 4'h0;
  localparam logic [3:0] ALU_OP_SUB  = 4'h1;
  localparam logic [3:0] ALU_OP_SLT  = 4'h2;
  localparam logic [3:0] ALU_OP_SLTU = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_EVAL,
    ST_RESOLVE,
    ST_REDIRECT
  } br_state_e;

  // 010 and 011 are the two reserved branch encodings
  function automatic logic f3_reserved(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // ALU operation that produces the compare result for a given funct3
  function automatic logic [3:0] alu_op_for(input logic [2:0] f3);
    case (f3)
      F3_BEQ, F3_BNE:   return ALU_OP_SUB;
      F3_BLT, F3_BGE:   return ALU_OP_SLT;
      F3_BLTU, F3_BGEU: return ALU_OP_SLTU;
      default:          return ALU_OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition: interprets the shared-ALU result for
// the latched funct3 and flags reserved encodings.
module br_cond_eval
  import riscv_br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  output logic            taken,
  output logic            illegal
);

  logic is_zero;

  assign is_zero = (alu_result == '0);

  // SUB result zero means equal; SLT/SLTU result nonzero means less-than
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           taken = is_zero;
      F3_BNE:           taken = !is_zero;
      F3_BLT, F3_BLTU:  taken = !is_zero;
      F3_BGE, F3_BGEU:  taken = is_zero;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts one branch from decode, borrows
// the shared ALU for the compare, resolves the outcome and drives a
// held PC redirect plus flush to fetch on mispredict.
module branch_resolve_ctrl
  import riscv_br_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  input  logic             br_pred_taken,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  alu_result,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             illegal_br,
  output logic [CNT_W-1:0] mispredict_cnt
);

  br_state_e        state_q, state_d;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  imm_q;
  logic             pred_q;
  logic             taken_q;
  logic [CNT_W-1:0] cnt_q;

  logic             eval_taken;
  logic             eval_illegal;
  logic             accept;
  logic             mispredict;

  assign accept     = (state_q == ST_IDLE) && br_valid;
  assign mispredict = (taken_q != pred_q);

  br_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .funct3     (f3_q),
    .alu_result (alu_result),
    .taken      (eval_taken),
    .illegal    (eval_illegal)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latched branch fields, resolved outcome and mispredict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q    <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      pred_q  <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        f3_q    <= br_funct3;
        pc_q    <= br_pc;
        imm_q   <= br_imm;
        pred_q  <= br_pred_taken;
        taken_q <= 1'b0;
      end
      if (state_q == ST_EVAL) taken_q <= eval_taken;
      if ((state_q == ST_RESOLVE) && mispredict && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d        = state_q;
    br_ready       = 1'b0;
    alu_req        = 1'b0;
    alu_op         = ALU_OP_NONE;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    illegal_br     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        br_ready = 1'b1;
        if (br_valid) state_d = f3_reserved(br_funct3) ? ST_RESOLVE : ST_ARB;
      end
      ST_ARB: begin
        alu_req = 1'b1;
        alu_op  = alu_op_for(f3_q);
        if (alu_gnt) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        resolve_valid = 1'b1;
        resolve_taken = taken_q;
        illegal_br    = eval_illegal;
        state_d       = mispredict ? ST_REDIRECT : ST_IDLE;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        redirect_pc    = pc_q + (taken_q ? imm_q : XLEN'(4));
        if (redirect_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed table, randomized
// branches against an operand-level reference model, counter saturation
// and asynchronous reset during a held redirect.
module tb_branch_resolve_ctrl;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_funct3;
  logic [XLEN-1:0]  br_pc;
  logic [XLEN-1:0]  br_imm;
  logic             br_pred_taken;
  logic             alu_req;
  logic             alu_gnt;
  logic [3:0]       alu_op;
  logic [XLEN-1:0]  alu_result;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_ack;
  logic             flush;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             illegal_br;
  logic [CNT_W-1:0] mispredict_cnt;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_funct3      (br_funct3),
    .br_pc          (br_pc),
    .br_imm         (br_imm),
    .br_pred_taken  (br_pred_taken),
    .alu_req        (alu_req),
    .alu_gnt        (alu_gnt),
    .alu_op         (alu_op),
    .alu_result     (alu_result),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ack   (redirect_ack),
    .flush          (flush),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .illegal_br     (illegal_br),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    int unsigned gnt_dly;
    int unsigned ack_dly;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_taken;
    logic [31:0] exp_rpc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural branch outcome from the source operands
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_op(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001: return 4'h1;
      3'b100, 3'b101: return 4'h2;
      3'b110, 3'b111: return 4'h3;
      default:        return 4'h0;
    endcase
  endfunction

  // Behaviour of the shared ALU the bench stands in for
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h1:    return a - b;
      4'h2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic is_rsvd(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Drive one branch end to end, checking every cycle; sampling on negedge
  task automatic run_txn(input vec_t v);
    logic mis;
    logic [3:0] op;
    op  = ref_op(v.f3);
    mis = (v.exp_taken != v.pred);
    @(negedge clk);
    chk("idle_br_ready", br_ready, 1'b1);
    chk("idle_alu_req", alu_req, 1'b0);
    br_valid = 1'b1; br_funct3 = v.f3; br_pc = v.pc; br_imm = v.imm; br_pred_taken = v.pred;
    @(negedge clk);
    br_valid = 1'b0; br_funct3 = 3'($urandom); br_pc = $urandom; br_imm = $urandom;
    chk("busy_br_ready", br_ready, 1'b0);
    if (!is_rsvd(v.f3)) begin
      for (int unsigned k = 0; k <= v.gnt_dly; k++) begin
        chk("arb_alu_req", alu_req, 1'b1);
        chk("arb_alu_op", alu_op, op);
        chk("arb_no_resolve", resolve_valid, 1'b0);
        if (k == v.gnt_dly) begin
          alu_gnt = 1'b1;
          alu_result = alu_model(op, v.a, v.b);
        end
        @(negedge clk);
      end
      alu_gnt = 1'b0;
      chk("eval_alu_req", alu_req, 1'b0);
      chk("eval_no_resolve", resolve_valid, 1'b0);
      @(negedge clk);
      alu_result = $urandom;
    end
    chk("res_valid", resolve_valid, 1'b1);
    chk("res_taken", resolve_taken, v.exp_taken);
    chk("res_illegal", illegal_br, is_rsvd(v.f3));
    chk("res_no_redirect", redirect_valid, 1'b0);
    chk("res_alu_req", alu_req, 1'b0);
    if (mis && model_cnt < CNT_MAX) model_cnt++;
    @(negedge clk);
    if (mis) begin
      for (int unsigned k = 0; k <= v.ack_dly; k++) begin
        chk("rdr_valid", redirect_valid, 1'b1);
        chk("rdr_flush", flush, 1'b1);
        chk("rdr_pc", redirect_pc, v.exp_rpc);
        chk("rdr_br_ready", br_ready, 1'b0);
        chk("rdr_resolve_low", resolve_valid, 1'b0);
        redirect_ack = (k == v.ack_dly);
        @(negedge clk);
      end
      redirect_ack = 1'b0;
    end
    chk("end_br_ready", br_ready, 1'b1);
    chk("end_redirect_low", redirect_valid, 1'b0);
    chk("end_flush_low", flush, 1'b0);
    chk("end_illegal_low", illegal_br, 1'b0);
    chk("mispredict_cnt", mispredict_cnt, model_cnt);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_br_ready"}, br_ready, 1'b1);
    chk({tag, "_alu_req"}, alu_req, 1'b0);
    chk({tag, "_alu_op"}, alu_op, 4'h0);
    chk({tag, "_redirect_valid"}, redirect_valid, 1'b0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    chk({tag, "_flush"}, flush, 1'b0);
    chk({tag, "_resolve_valid"}, resolve_valid, 1'b0);
    chk({tag, "_resolve_taken"}, resolve_taken, 1'b0);
    chk({tag, "_illegal_br"}, illegal_br, 1'b0);
    chk({tag, "_cnt"}, mispredict_cnt, 6'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    rst_n = 1'b0; br_valid = 1'b0; br_funct3 = '0; br_pc = '0; br_imm = '0;
    br_pred_taken = 1'b0; alu_gnt = 1'b0; alu_result = '0; redirect_ack = 1'b0;

    //         f3      pc            imm           pred gd ad a             b             taken rpc
    tbl[0] = '{3'b000, 32'h0000_0100, 32'h0000_0020, 1'b0, 0, 0, 32'd7,        32'd7,        1'b1, 32'h0000_0120};
    tbl[1] = '{3'b001, 32'h0000_0140, 32'h0000_0040, 1'b0, 0, 0, 32'd9,        32'd9,        1'b0, 32'h0000_0144};
    tbl[2] = '{3'b110, 32'h0000_0200, 32'h0000_0080, 1'b1, 5, 0, 32'd9,        32'd3,        1'b0, 32'h0000_0204};
    tbl[3] = '{3'b101, 32'hFFFF_FFF8, 32'h0000_0010, 1'b0, 0, 3, 32'd5,        32'd3,        1'b1, 32'h0000_0008};
    tbl[4] = '{3'b010, 32'h0000_0300, 32'h0000_0010, 1'b0, 0, 0, 32'd0,        32'd0,        1'b0, 32'h0000_0304};
    tbl[5] = '{3'b011, 32'h0000_0400, 32'h0000_0010, 1'b1, 0, 1, 32'd0,        32'd0,        1'b0, 32'h0000_0404};
    tbl[6] = '{3'b100, 32'h0000_1000, 32'hFFFF_FFF0, 1'b0, 2, 0, 32'hFFFF_FFFF, 32'd1,        1'b1, 32'h0000_0FF0};
    tbl[7] = '{3'b111, 32'h0000_2000, 32'h0000_0100, 1'b1, 1, 0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_2004};

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Randomized branches against the operand-level model
    for (int i = 0; i < 200; i++) begin
      v.f3      = 3'($urandom);
      v.pc      = $urandom;
      v.imm     = $urandom;
      v.pred    = 1'($urandom);
      v.gnt_dly = $urandom_range(0, 3);
      v.ack_dly = $urandom_range(0, 2);
      v.a       = $urandom;
      case ($urandom_range(0, 2))
        0:       v.b = v.a;
        1:       v.b = v.a ^ (32'h1 << $urandom_range(0, 31));
        default: v.b = $urandom;
      endcase
      v.exp_taken = ref_taken(v.f3, v.a, v.b);
      v.exp_rpc   = v.exp_taken ? v.pc + v.imm : v.pc + 32'd4;
      run_txn(v);
    end

    // Saturation: more than 2^CNT_W mispredicts via reserved funct3 with pred=1
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      v = '{3'b010, 32'h0000_0500, 32'h0, 1'b1, 0, 0, 32'd0, 32'd0, 1'b0, 32'h0000_0504};
      run_txn(v);
    end
    chk("cnt_saturated", mispredict_cnt, 6'h3F);

    // Reset while a redirect is held waiting for ack
    @(negedge clk);
    br_valid = 1'b1; br_funct3 = 3'b000; br_pc = 32'h0000_0600; br_imm = 32'h0000_0008; br_pred_taken = 1'b0;
    @(negedge clk);
    br_valid = 1'b0;
    alu_gnt = 1'b1; alu_result = 32'h0;
    @(negedge clk);
    alu_gnt = 1'b0;
    @(negedge clk);
    chk("rst_seq_resolve", resolve_valid, 1'b1);
    @(negedge clk);
    chk("rst_seq_redirect", redirect_valid, 1'b1);
    chk("rst_seq_rpc", redirect_pc, 32'h0000_0608);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    chk_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    model_cnt = 0;
    redirect_ack = 1'b1;
    @(negedge clk);
    chk("ack_in_idle_ignored", redirect_valid, 1'b0);
    redirect_ack = 1'b0;
    run_txn(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
